// File: rtl/cam_sensor_emulator.sv
// cam_sensor_emulator
// Synthetic D5M-style image source. Produces a free-running pixel clock (clk/2) and
// frame/line-valid framed 12-bit test patterns so the capture path can run without a sensor.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       run request, sampled only at frame boundaries
//   pattern      test pattern select, latched at frame start
//   cam_pixclk   pixel clock, clk/2 square wave
//   cam_fval     frame valid
//   cam_lval     line valid
//   cam_data     12-bit pixel data (0 whenever lval is low)
//   frame_done   1-clk pulse when the last active pixel of a frame is left
//   frame_cnt    completed-frame counter (wraps)
//   busy         high whenever the generator is not idle
module cam_sensor_emulator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned PRE_PIX  = 8,
  parameter int unsigned V_BLANK  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern,
  output logic        cam_pixclk,
  output logic        cam_fval,
  output logic        cam_lval,
  output logic [11:0] cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BlankMaxHv = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BlankMax = (PRE_PIX > BlankMaxHv) ? PRE_PIX : BlankMaxHv;
  localparam int unsigned CW = (BlankMax > 1) ? $clog2(BlankMax) : 1;

  localparam logic [XW-1:0] XLast   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLast   = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] PreLast = CW'(PRE_PIX - 1);
  localparam logic [CW-1:0] HbLast  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VbLast  = CW'(V_BLANK - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StActive,
    StHblank,
    StVblank
  } state_e;

  // With no pre-frame porch a frame starts straight on line 0.
  localparam state_e StStart = (PRE_PIX == 0) ? StActive : StPre;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          pixclk_q;
  logic          fval_q, fval_d;
  logic          lval_q, lval_d;
  logic [11:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          tick;
  logic [11:0]   x12, y12;

  // Pixel tick: the clk edge on which pixclk falls, so outputs straddle the next rising edge.
  assign tick = pixclk_q;

  // Sequencing: state, position counters, pattern latch and frame counter.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            pat_d   = pattern;
            state_d = StStart;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
          end
        end
        StPre: begin
          if (cnt_q == PreLast) begin
            state_d = StActive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StActive: begin
          if (x_q == XLast) begin
            x_d   = '0;
            cnt_d = '0;
            if (y_q == YLast) begin
              state_d = StVblank;
              done_d  = 1'b1;
              fcnt_d  = fcnt_q + 16'd1;
            end else begin
              state_d = StHblank;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
        StHblank: begin
          if (cnt_q == HbLast) begin
            state_d = StActive;
            y_d     = y_q + 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StVblank: begin
          if (cnt_q == VbLast) begin
            cnt_d = '0;
            x_d   = '0;
            y_d   = '0;
            if (enable) begin
              pat_d   = pattern;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered sensor outputs, derived from the state being entered on this tick.
  always_comb begin
    fval_d = fval_q;
    lval_d = lval_q;
    data_d = data_q;
    x12    = 12'(x_d);
    y12    = 12'(y_d);
    if (tick) begin
      fval_d = (state_d == StPre) || (state_d == StActive) || (state_d == StHblank);
      lval_d = (state_d == StActive);
      data_d = '0;
      if (lval_d) begin
        unique case (pat_d)
          2'd0:    data_d = x12;
          2'd1:    data_d = y12;
          2'd2:    data_d = (x12[3] ^ y12[3]) ? 12'hFFF : 12'h000;
          default: data_d = x12 + fcnt_q[11:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      pat_q    <= '0;
      fcnt_q   <= '0;
      pixclk_q <= 1'b0;
      fval_q   <= 1'b0;
      lval_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      fcnt_q   <= fcnt_d;
      pixclk_q <= ~pixclk_q;
      fval_q   <= fval_d;
      lval_q   <= lval_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign cam_pixclk = pixclk_q;
  assign cam_fval   = fval_q;
  assign cam_lval   = lval_q;
  assign cam_data   = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_cam_sensor_emulator.sv
module tb_cam_sensor_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4x3 frame, H_BLANK 2, PRE 3, V_BLANK 5 -> 24 pixels per frame.
  logic        rst_a = 1'b0, en_a = 1'b0;
  logic [1:0]  pat_a = 2'd0;
  logic        pclk_a, fval_a, lval_a, fd_a, busy_a;
  logic [11:0] data_a;
  logic [15:0] fcnt_a;

  // Instance B: 16x16 frame for the checkerboard.
  logic        rst_b = 1'b0, en_b = 1'b0;
  logic [1:0]  pat_b = 2'd0;
  logic        pclk_b, fval_b, lval_b, fd_b, busy_b;
  logic [11:0] data_b;
  logic [15:0] fcnt_b;

  cam_sensor_emulator #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .PRE_PIX(3), .V_BLANK(5)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .enable(en_a), .pattern(pat_a),
    .cam_pixclk(pclk_a), .cam_fval(fval_a), .cam_lval(lval_a), .cam_data(data_a),
    .frame_done(fd_a), .frame_cnt(fcnt_a), .busy(busy_a)
  );

  cam_sensor_emulator #(
    .H_ACTIVE(16), .H_BLANK(2), .V_ACTIVE(16), .PRE_PIX(3), .V_BLANK(5)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .enable(en_b), .pattern(pat_b),
    .cam_pixclk(pclk_b), .cam_fval(fval_b), .cam_lval(lval_b), .cam_data(data_b),
    .frame_done(fd_b), .frame_cnt(fcnt_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  int fd_cnt_a = 0;
  int fd_cnt_b = 0;

  // Per-pixel framing of one 24-pixel frame of instance A, pixel 0 in the MSB.
  logic [23:0] exp_f;
  logic [23:0] exp_l;

  // frame_done is sampled every clk, so a pulse longer than one clk counts more than once.
  always @(negedge clk) begin
    if (fd_a) fd_cnt_a++;
    if (fd_b) fd_cnt_b++;
  end

  // Advance to the next pixclk-high sample point (one pixel per call once aligned).
  task automatic next_pix_a;
    @(negedge clk);
    if (!pclk_a) @(negedge clk);
  endtask

  task automatic next_pix_b;
    @(negedge clk);
    if (!pclk_b) @(negedge clk);
  endtask

  // Reset, then release; returns at PRE pixel 0 if e=1, else at an idle sample.
  task automatic restart_a(input logic [1:0] p, input logic e);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    pat_a = p;
    en_a  = e;
    rst_a = 1'b1;
    next_pix_a();
    next_pix_a();
  endtask

  task automatic restart_b(input logic [1:0] p, input logic e);
    @(negedge clk);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    pat_b = p;
    en_b  = e;
    rst_b = 1'b1;
    next_pix_b();
    next_pix_b();
  endtask

  task automatic test_reset;
    rst_a = 1'b0;
    en_a  = 1'b1;
    pat_a = 2'd0;
    repeat (4) @(negedge clk);
    checks++; if (pclk_a !== 1'b0) begin errors++; $display("FAIL rst_pixclk: got %b expected 0", pclk_a); end
    checks++; if (fval_a !== 1'b0) begin errors++; $display("FAIL rst_fval: got %b expected 0", fval_a); end
    checks++; if (lval_a !== 1'b0) begin errors++; $display("FAIL rst_lval: got %b expected 0", lval_a); end
    checks++; if (data_a !== 12'h000) begin errors++; $display("FAIL rst_data: got %h expected 000", data_a); end
    checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", fd_a); end
    checks++; if (fcnt_a !== 16'h0000) begin errors++; $display("FAIL rst_fcnt: got %h expected 0000", fcnt_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    rst_a = 1'b1;
    @(negedge clk);
    checks++; if (pclk_a !== 1'b1) begin errors++; $display("FAIL rel_pixclk1: got %b expected 1", pclk_a); end
    checks++; if (fval_a !== 1'b0) begin errors++; $display("FAIL rel_fval1: got %b expected 0", fval_a); end
    @(negedge clk);
    checks++; if (pclk_a !== 1'b0) begin errors++; $display("FAIL rel_pixclk2: got %b expected 0", pclk_a); end
    checks++; if (fval_a !== 1'b1) begin errors++; $display("FAIL rel_fval2: got %b expected 1", fval_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rel_busy2: got %b expected 1", busy_a); end
    @(negedge clk);
    checks++; if (pclk_a !== 1'b1) begin errors++; $display("FAIL rel_pixclk3: got %b expected 1", pclk_a); end
    checks++; if (lval_a !== 1'b0) begin errors++; $display("FAIL rel_lval3: got %b expected 0", lval_a); end
  endtask

  // Continues from test_reset: the frame already started, enable drops now.
  task automatic test_single_frame;
    int pulses = 0;
    logic prev_l = 1'b0;
    logic [11:0] ed;
    int fd0 = fd_cnt_a;
    en_a = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i != 0) next_pix_a();
      ed = exp_l[23-i] ? 12'((i - 3) % 6) : 12'h000;
      checks++; if (fval_a !== exp_f[23-i]) begin errors++; $display("FAIL sf_fval[%0d]: got %b expected %b", i, fval_a, exp_f[23-i]); end
      checks++; if (lval_a !== exp_l[23-i]) begin errors++; $display("FAIL sf_lval[%0d]: got %b expected %b", i, lval_a, exp_l[23-i]); end
      checks++; if (data_a !== ed) begin errors++; $display("FAIL sf_data[%0d]: got %h expected %h", i, data_a, ed); end
      if (lval_a && !prev_l) pulses++;
      prev_l = lval_a;
    end
    next_pix_a();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL sf_busy_end: got %b expected 0", busy_a); end
    checks++; if (fval_a !== 1'b0) begin errors++; $display("FAIL sf_fval_end: got %b expected 0", fval_a); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL sf_lval_pulses: got %0d expected 3", pulses); end
    checks++; if (fcnt_a !== 16'd1) begin errors++; $display("FAIL sf_fcnt: got %0d expected 1", fcnt_a); end
    checks++; if (fd_cnt_a - fd0 != 1) begin errors++; $display("FAIL sf_done_pulses: got %0d expected 1", fd_cnt_a - fd0); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] ed;
    int fd0;
    restart_a(2'd1, 1'b1);
    fd0 = fd_cnt_a;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 24; i++) begin
        if (f != 0 || i != 0) next_pix_a();
        ed = exp_l[23-i] ? 12'((i - 3) / 6) : 12'h000;
        checks++; if (fval_a !== exp_f[23-i]) begin errors++; $display("FAIL bb_fval[%0d][%0d]: got %b expected %b", f, i, fval_a, exp_f[23-i]); end
        checks++; if (data_a !== ed) begin errors++; $display("FAIL bb_data[%0d][%0d]: got %h expected %h", f, i, data_a, ed); end
        if (i == 19) begin
          checks++; if (fcnt_a !== 16'(f + 1)) begin errors++; $display("FAIL bb_fcnt[%0d]: got %0d expected %0d", f, fcnt_a, f + 1); end
          checks++; if (fd_cnt_a - fd0 != f + 1) begin errors++; $display("FAIL bb_done[%0d]: got %0d expected %0d", f, fd_cnt_a - fd0, f + 1); end
        end
      end
    end
    next_pix_a();
    checks++; if (fval_a !== 1'b1) begin errors++; $display("FAIL bb_next_frame_fval: got %b expected 1", fval_a); end
  endtask

  task automatic test_checker;
    logic [11:0] ed;
    int ones = 0;
    restart_b(2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (fval_b !== 1'b1 || lval_b !== 1'b0) begin errors++; $display("FAIL ck_pre[%0d]: got fval %b lval %b expected 1 0", i, fval_b, lval_b); end
      next_pix_b();
    end
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        ed = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
        checks++; if (lval_b !== 1'b1 || data_b !== ed) begin errors++; $display("FAIL ck_pix[x%0d,y%0d]: got lval %b data %h expected 1 %h", x, y, lval_b, data_b, ed); end
        if (data_b === 12'hFFF) ones++;
        // Mid-frame pattern change must not take effect until the next frame.
        if (y == 4 && x == 0) pat_b = 2'd0;
        next_pix_b();
      end
      if (y < 15) begin
        for (int h = 0; h < 2; h++) begin
          checks++; if (lval_b !== 1'b0 || data_b !== 12'h000) begin errors++; $display("FAIL ck_hb[y%0d]: got lval %b data %h expected 0 000", y, lval_b, data_b); end
          next_pix_b();
        end
      end
    end
    checks++; if (ones != 128) begin errors++; $display("FAIL ck_fff_count: got %0d expected 128", ones); end
    checks++; if (fval_b !== 1'b0) begin errors++; $display("FAIL ck_vblank_fval: got %b expected 0", fval_b); end
    checks++; if (fcnt_b !== 16'd1) begin errors++; $display("FAIL ck_fcnt: got %0d expected 1", fcnt_b); end
    repeat (8) next_pix_b();
    for (int x = 0; x < 16; x++) begin
      checks++; if (data_b !== 12'(x)) begin errors++; $display("FAIL ck_newpat[x%0d]: got %h expected %h", x, data_b, 12'(x)); end
      next_pix_b();
    end
  endtask

  task automatic test_wrap;
    logic [11:0] tbl [2][4];
    logic [11:0] ed;
    tbl[0][0] = 12'hFFF; tbl[0][1] = 12'h000; tbl[0][2] = 12'h001; tbl[0][3] = 12'h002;
    tbl[1][0] = 12'h000; tbl[1][1] = 12'h001; tbl[1][2] = 12'h002; tbl[1][3] = 12'h003;
    restart_a(2'd3, 1'b0);
    force dut_a.fcnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut_a.fcnt_q;
    checks++; if (fcnt_a !== 16'hFFFF) begin errors++; $display("FAIL wr_preload: got %h expected ffff", fcnt_a); end
    en_a = 1'b1;
    next_pix_a();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 24; i++) begin
        if (f != 0 || i != 0) next_pix_a();
        ed = exp_l[23-i] ? tbl[f][(i - 3) % 6] : 12'h000;
        checks++; if (data_a !== ed) begin errors++; $display("FAIL wr_data[%0d][%0d]: got %h expected %h", f, i, data_a, ed); end
        if (i == 19) begin
          checks++; if (fcnt_a !== 16'(f)) begin errors++; $display("FAIL wr_fcnt[%0d]: got %h expected %h", f, fcnt_a, 16'(f)); end
        end
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_abort;
    restart_a(2'd0, 1'b1);
    repeat (11) next_pix_a();
    checks++; if (lval_a !== 1'b1 || data_a !== 12'h002) begin errors++; $display("FAIL ab_pre: got lval %b data %h expected 1 002", lval_a, data_a); end
    #2 rst_a = 1'b0;
    #1;
    checks++; if (pclk_a !== 1'b0) begin errors++; $display("FAIL ab_pixclk: got %b expected 0", pclk_a); end
    checks++; if (fval_a !== 1'b0) begin errors++; $display("FAIL ab_fval: got %b expected 0", fval_a); end
    checks++; if (lval_a !== 1'b0) begin errors++; $display("FAIL ab_lval: got %b expected 0", lval_a); end
    checks++; if (data_a !== 12'h000) begin errors++; $display("FAIL ab_data: got %h expected 000", data_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b expected 0", busy_a); end
    @(negedge clk);
    pat_a = 2'd1;
    rst_a = 1'b1;
    next_pix_a();
    next_pix_a();
    checks++; if (fval_a !== 1'b1 || lval_a !== 1'b0) begin errors++; $display("FAIL ab_restart_pre: got fval %b lval %b expected 1 0", fval_a, lval_a); end
    checks++; if (fcnt_a !== 16'd0) begin errors++; $display("FAIL ab_fcnt: got %0d expected 0", fcnt_a); end
    repeat (3) next_pix_a();
    for (int x = 0; x < 4; x++) begin
      checks++; if (lval_a !== 1'b1 || data_a !== 12'h000) begin errors++; $display("FAIL ab_line0[%0d]: got lval %b data %h expected 1 000", x, lval_a, data_a); end
      next_pix_a();
    end
    checks++; if (lval_a !== 1'b0) begin errors++; $display("FAIL ab_hblank: got %b expected 0", lval_a); end
    en_a = 1'b0;
  endtask

  initial begin
    exp_f = 24'b1111111111111111111_00000;
    exp_l = 24'b000_1111_00_1111_00_1111_00000;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_checker();
    test_wrap();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_sensor_emulator.md
Name: cam_sensor_emulator

Overview:
Synthetic image-sensor source that drives the same parallel pixel interface a D5M-class camera presents to the camera controller: pixclk, fval, lval and 12-bit data. It generates deterministic test frames so the capture path, SDRAM write-back and NN front end can be exercised in simulation and on board without a physical sensor. It sits in place of the camera pins, looped back into the camera controller conduit.

Parameters:
H_ACTIVE, 640, active pixels per line (>=1)
H_BLANK, 16, lval-low pixels between lines inside a frame (>=1)
V_ACTIVE, 480, active lines per frame (>=1)
PRE_PIX, 8, fval-high/lval-low pixels before first line
V_BLANK, 64, fval-low pixels after last line (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled only at frame boundaries
pattern  in  2  pattern select; latched at frame start
cam_pixclk  out  1  pixel clock, clk/2 square wave
cam_fval  out  1  frame valid
cam_lval  out  1  line valid
cam_data  out  12  pixel data
frame_done  out  1  1-clk pulse at end of each frame's last active pixel
frame_cnt  out  16  completed-frame counter
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0): cam_pixclk=0, cam_fval=0, cam_lval=0, cam_data=0, frame_done=0, frame_cnt=0, busy=0, state=IDLE, all counters 0; mid-frame reset aborts frame immediately.
- pixclk register toggles every clk after reset release; runs even in IDLE.
- Pixel tick = clk edge where cam_pixclk goes 1->0. All other outputs change only on pixel ticks, so each value is stable for 2 clk and straddles exactly one pixclk rising edge (receiver samples on rising).
- First pixel tick occurs on the 2nd clk edge after reset release.
- FSM, advanced on pixel ticks only:
  IDLE: fval=0, lval=0, data=0. enable=1 -> latch pattern, PRE (fval=1).
  PRE: fval=1, lval=0 for PRE_PIX pixels -> ACTIVE (line y=0). PRE_PIX=0 skips directly to ACTIVE.
  ACTIVE: fval=1, lval=1, x counts 0..H_ACTIVE-1. At x=H_ACTIVE-1: if y<V_ACTIVE-1 -> HBLANK, else -> VBLANK.
  HBLANK: fval=1, lval=0 for H_BLANK pixels, then y++ and x=0 -> ACTIVE.
  VBLANK: fval=0, lval=0 for V_BLANK pixels; then enable=1 -> PRE (re-latch pattern), else -> IDLE.
- Frame period = PRE_PIX + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BLANK pixels, back to back while enable=1.
- Deasserting enable mid-frame has no effect until the current frame completes VBLANK.
- pattern changes mid-frame are ignored.
- cam_data in ACTIVE, with x,y,frame_cnt taken mod 4096:
  0 = x; 1 = y; 2 = 12'hFFF if x[3]^y[3] else 12'h000; 3 = (x + frame_cnt) mod 4096.
- cam_data=0 whenever lval=0.
- frame_done: 1-clk pulse on the pixel tick that leaves the last ACTIVE pixel (entry to VBLANK). frame_cnt increments on the same edge and wraps 16'hFFFF->0.
- busy=1 from entry to PRE until return to IDLE.
- Counter widths are $clog2 of their limits; no overflow beyond the parameter bounds.

Test Plan:
1. Reset: hold reset_n=0 with enable=1 -> all outputs 0. Release -> pixclk toggles each clk; fval rises on the 2nd clk edge (first tick).
2. Small frame, H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, PRE_PIX=3, V_BLANK=5, pattern=0, enable pulsed for one frame -> exactly 3 lval pulses of 4 rising-edge samples each, data 0,1,2,3 per line. Frame = 24 pixels = 48 clk; busy drops after VBLANK.
3. Same parameters, pattern=1, enable held -> line data 0,0,0,0 / 1,1,1,1 / 2,2,2,2. Frames repeat with fval low exactly 5 pixels between them. frame_cnt counts 1,2,3 with one frame_done pulse each.
4. H_ACTIVE=16, V_ACTIVE=16, pattern=2 -> data=FFF exactly where x[3]^y[3]=1 (e.g. x=8,y=0 -> FFF; x=8,y=8 -> 000). Switching pattern to 0 mid-frame has no effect until the next frame.
5. pattern=3, preload by running to frame_cnt=16'hFFFF -> next frame_done wraps frame_cnt to 0; the frame after that has data x+0.
6. Assert reset_n=0 mid-line -> fval, lval, data and pixclk go to 0 immediately (asynchronously). After release, the next frame restarts from PRE with x=y=0.
